pulse_extract_multi: RTL
========================

Name: pulse_extract_multi

Overview:
- Multi-channel, single-clock edge/pulse extractor; successor to the single-channel, rising-edge-only pulse extractor.
- Per channel: a selectable edge mode, a saturating pending-event counter, and a valid/ready handshake, so a consumer such as the PIO/DMA request logic can drain events at its own rate without losing them.
- Sits between AHB-side level/strobe signals and PIO/DMA request inputs, where the two clocks are edge-aligned and the block runs on the faster clock.

Parameters:
- CHANNELS, 4, number of independent channels (1..32).
- CNT_W, 4, pending-counter width; counter saturates at 2^CNT_W-1.
- INPUT_REG, 0, 1 inserts one register stage on in before edge detection (+1 cycle latency).

Ports:
- clk  in  1  block clock; all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- in  in  CHANNELS  sampled input levels, one per channel.
- mode  in  2*CHANNELS  per-channel edge select; ch i uses mode[2i+1:2i].
- out_valid  out  CHANNELS  channel has at least one pending event.
- out_ready  in  CHANNELS  consumer accepts one event this cycle.
- pending  out  CHANNELS*CNT_W  per-channel pending count; ch i uses [CNT_W*i +: CNT_W].
- overflow  out  CHANNELS  sticky; an event was dropped at saturation.
- overflow_clr  in  CHANNELS  per-channel clear of overflow.

Behaviour:
- Mode encoding: 00 OFF, 01 RISE, 10 FALL, 11 BOTH.
- Sample path:
  - s = in when INPUT_REG=0, else in registered once.
  - prev <= s every cycle, regardless of mode.
- Edge detection:
  - rise = s & ~prev; fall = ~s & prev.
  - event = (RISE & rise) | (FALL & fall) | (BOTH & (rise|fall)); OFF gives no events.
- Arming:
  - armed flag, reset 0, set after 1+INPUT_REG cycles following reset deassertion.
  - While unarmed, events are suppressed, so an input already high at reset release produces no spurious edge.
- Counter update, per channel, with take = out_valid & out_ready:
  - event & !take: cnt+1, or hold at max and set overflow.
  - !event & take: cnt-1.
  - event & take: unchanged (never sets overflow, even at max).
  - neither: unchanged.
- Outputs:
  - out_valid = (cnt != 0), driven from a registered counter.
  - Latency: edge on in → out_valid high is 1 cycle (INPUT_REG=0) or 2 cycles (INPUT_REG=1).
  - out_ready while out_valid=0 is ignored; the counter never underflows.
  - pending = cnt, registered.
- overflow:
  - Set has priority over overflow_clr in the same cycle.
  - Cleared only by overflow_clr or reset.
- Mode changes:
  - Take effect the same cycle.
  - Do not flush pending; switching to OFF stops new events but lets the consumer drain the backlog.
- Reset, including mid-operation: clears cnt, overflow, prev, input register and armed.
  - out_valid=0, pending=0, overflow=0 from the first cycle reset is seen high.
- Channels are fully independent; no cross-channel arbitration.

Decomposition:
- Shared package pulse_extract_pkg holds:
  - mode localparams MODE_OFF/RISE/FALL/BOTH (2-bit);
  - the edge_mode_t typedef.
- One natural sub-module, pulse_extract_chan, covering one channel:
  - optional input register and prev register;
  - edge detection;
  - counter and overflow logic.
- Top level instantiates CHANNELS copies plus a single shared armed flag.

Test Plan:
- Reset release with in=4'b1111, mode=RISE on all channels → no out_valid for 20 cycles; pending=0 on every channel.
- ch0 RISE, one 0→1 edge, out_ready=1 → out_valid high for exactly 1 cycle, 1 cycle after the edge; repeat with INPUT_REG=1 → 2-cycle latency.
- ch1 BOTH, toggle in every cycle for 6 cycles, out_ready=0 → pending=6, out_valid=1; then out_ready=1 → drains 6 events over 6 cycles to 0.
- ch2 FALL, CNT_W=4, 17 falling edges with out_ready=0 → pending saturates at 15, overflow=1; overflow_clr pulsed together with an 18th edge → overflow stays 1; a later clr alone → 0.
- ch3 RISE, pending=1 with out_ready=1 and a new edge in the same cycle → pending stays 1, out_valid stays 1, no overflow.
- Mid-operation reset with pending=5 on ch1 → next cycle pending=0, out_valid=0; re-arm then behaves as the first scenario.

Source files
------------

// File: rtl/pulse_extract_pkg.sv
// pulse_extract_pkg: edge-mode encoding and edge qualifier shared by the pulse extractor.
package pulse_extract_pkg;
   typedef logic [1:0] edge_mode_t;
   localparam edge_mode_t MODE_OFF  = 2'b00;
   localparam edge_mode_t MODE_RISE = 2'b01;
   localparam edge_mode_t MODE_FALL = 2'b10;
   localparam edge_mode_t MODE_BOTH = 2'b11;
   // bit 0 enables rising edges and bit 1 falling edges, so BOTH is their union
   function automatic logic edge_event(input edge_mode_t m, input logic s, input logic prev);
      return (m[0] & s & ~prev) | (m[1] & ~s & prev);
   endfunction
endpackage

// File: rtl/pulse_extract_chan.sv
// pulse_extract_chan: one channel of edge detection feeding a saturating
// pending-event counter drained through a valid/ready handshake.
module pulse_extract_chan
   import pulse_extract_pkg::*;
#(
   parameter int CNT_W     = 4,
   parameter int INPUT_REG = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in,
   input  logic             armed,
   input  edge_mode_t       mode,
   input  logic             out_ready,
   input  logic             overflow_clr,
   output logic             out_valid,
   output logic [CNT_W-1:0] pending,
   output logic             overflow
);
   logic             w_s, w_event, w_take, w_full;
   logic             r_prev, r_ovf;
   logic [CNT_W-1:0] r_cnt;
   if (INPUT_REG != 0) begin : g_ireg
      logic r_in;
      always_ff @(posedge clk) r_in <= reset ? 1'b0 : in;
      assign w_s = r_in;
   end else begin : g_noreg
      assign w_s = in;
   end
   assign w_event = armed & edge_event(mode, w_s, r_prev);
   assign w_take  = out_valid & out_ready;
   assign w_full  = &r_cnt;
   // a simultaneous event and take cancel, so saturation only drops unmatched events
   always_ff @(posedge clk) begin
      if (reset) begin
         r_prev <= 1'b0;
         r_cnt  <= '0;
         r_ovf  <= 1'b0;
      end else begin
         r_prev <= w_s;
         if (w_event && !w_take && !w_full) r_cnt <= r_cnt + 1'b1;
         else if (!w_event && w_take) r_cnt <= r_cnt - 1'b1;
         if (w_event && !w_take && w_full) r_ovf <= 1'b1;
         else if (overflow_clr) r_ovf <= 1'b0;
      end
   end
   assign out_valid = |r_cnt;
   assign pending   = r_cnt;
   assign overflow  = r_ovf;
endmodule

// File: rtl/pulse_extract_multi.sv
// pulse_extract_multi: CHANNELS independent edge extractors sharing one arming flag
// that masks the bogus edges seen while the sample path refills after reset.
module pulse_extract_multi
   import pulse_extract_pkg::*;
#(
   parameter int CHANNELS  = 4,
   parameter int CNT_W     = 4,
   parameter int INPUT_REG = 0
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [CHANNELS-1:0]       in,
   input  logic [2*CHANNELS-1:0]     mode,
   output logic [CHANNELS-1:0]       out_valid,
   input  logic [CHANNELS-1:0]       out_ready,
   output logic [CHANNELS*CNT_W-1:0] pending,
   output logic [CHANNELS-1:0]       overflow,
   input  logic [CHANNELS-1:0]       overflow_clr
);
   localparam logic [1:0] ARM_N = 2'(1 + INPUT_REG);
   logic [1:0] r_arm_cnt;
   logic       w_armed;
   assign w_armed = (r_arm_cnt == ARM_N);
   always_ff @(posedge clk) begin
      if (reset) r_arm_cnt <= '0;
      else if (!w_armed) r_arm_cnt <= r_arm_cnt + 1'b1;
   end
   for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
      pulse_extract_chan #(.CNT_W(CNT_W), .INPUT_REG(INPUT_REG)) u_chan (
         .clk          (clk),
         .reset        (reset),
         .in           (in[g]),
         .armed        (w_armed),
         .mode         (mode[2*g +: 2]),
         .out_ready    (out_ready[g]),
         .overflow_clr (overflow_clr[g]),
         .out_valid    (out_valid[g]),
         .pending      (pending[CNT_W*g +: CNT_W]),
         .overflow     (overflow[g])
      );
   end
endmodule
